serial_to_parallel: RTL and testbench

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/p2s_pkg.sv | 17 +
 rtl/serial_to_parallel_if.sv | 24 ++
 rtl/serial_to_parallel.sv | 120 ++++++++++++
 tb/tb_serial_to_parallel.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared definitions for the serial-to-parallel receiver: word width, FSM state type
// and the parity helper.
package p2s_pkg;

    localparam int P2S_SERIAL_LEN = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_t;

    // Returns 1 when the frame (data plus trailing even-parity bit) has an odd number of ones.
    function automatic logic parity_odd(input logic [P2S_SERIAL_LEN:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input stream and parallel output handshake of serial_to_parallel.
// The master side drives the serial stream and consumes words; the slave is the receiver.
interface serial_to_parallel_if;

    logic                                serial_in;
    logic                                frame_start;
    logic                                out_ready;
    logic [p2s_pkg::P2S_SERIAL_LEN-1:0]  parallel_out;
    logic                                out_valid;
    logic                                busy;
    logic                                overrun;
    logic                                parity_err;

    modport master (
        output serial_in, frame_start, out_ready,
        input  parallel_out, out_valid, busy, overrun, parity_err
    );

    modport slave (
        input  serial_in, frame_start, out_ready,
        output parallel_out, out_valid, busy, overrun, parity_err
    );

endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with a one-word output register and overrun detection.
// Define S2P_PARITY_EN to expect a trailing even-parity bit per frame and report parity_err.
module serial_to_parallel
    import p2s_pkg::*;
(
    input logic             clk,
    input logic             rst,
    serial_to_parallel_if.slave bus
);

`ifdef S2P_PARITY_EN
    localparam int FRAME_LEN = P2S_SERIAL_LEN + 1;
`else
    localparam int FRAME_LEN = P2S_SERIAL_LEN;
`endif
    localparam int CNT_W = $clog2(P2S_SERIAL_LEN + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    s2p_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]       shreg_q, shreg_d;
    logic [FRAME_LEN-1:0]       frame_s;
    logic                       complete_s;
    logic [P2S_SERIAL_LEN-1:0]  dout_q, dout_d;
    logic                       valid_q, valid_d;
    logic                       ovr_q, ovr_d;
    logic                       perr_q, perr_d;

    // Receive path: frame_start always restarts, a frame completes on its final bit.
    always_comb begin
        frame_s    = shreg_q | (FRAME_LEN'(bus.serial_in) << cnt_q);
        complete_s = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(1);
                    shreg_d = FRAME_LEN'(bus.serial_in);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.frame_start) begin
                    cnt_d   = CNT_W'(1);
                    shreg_d = FRAME_LEN'(bus.serial_in);
                end else if (cnt_q == LAST_CNT) begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                    shreg_d    = {FRAME_LEN{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = frame_s;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                shreg_d = {FRAME_LEN{1'b0}};
            end
        endcase
    end

    // Output register: a completed word is dropped only when the pending one is not consumed.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        perr_d  = perr_q;
        if (complete_s) begin
            if (!valid_q || bus.out_ready) begin
                dout_d  = frame_s[P2S_SERIAL_LEN-1:0];
                valid_d = 1'b1;
`ifdef S2P_PARITY_EN
                perr_d  = parity_odd(frame_s);
`else
                perr_d  = 1'b0;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            shreg_q <= {FRAME_LEN{1'b0}};
            dout_q  <= {P2S_SERIAL_LEN{1'b0}};
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.parallel_out = dout_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = (state_q == SHIFT);
    assign bus.overrun      = ovr_q;
    assign bus.parity_err   = perr_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized self-checking bench for serial_to_parallel against a queue-based frame model,
// with directed scenarios pinned by literal expectations.
module tb_serial_to_parallel;
    import p2s_pkg::*;

`ifdef S2P_PARITY_EN
    localparam int FLEN = P2S_SERIAL_LEN + 1;
`else
    localparam int FLEN = P2S_SERIAL_LEN;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_to_parallel_if bus();
    serial_to_parallel dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    // Behavioural model: bits of the frame in flight, plus the expected outputs.
    bit        m_active = 1'b0;
    bit        q_bits[$];
    bit [31:0] m_word = 0;
    bit        m_valid = 1'b0;
    bit        m_ovr = 1'b0;
    bit        m_perr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        q_bits.delete();
        m_word = 0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge(input bit fs, input bit sin, input bit rdy);
        bit        done;
        bit [31:0] data;
        bit        par;
        done = 1'b0;
        if (fs) begin
            q_bits.delete();
            q_bits.push_back(sin);
            m_active = 1'b1;
        end else if (m_active) begin
            q_bits.push_back(sin);
            if (q_bits.size() == FLEN) begin
                done = 1'b1;
                m_active = 1'b0;
            end
        end
        m_ovr = 1'b0;
        if (done) begin
            data = 0;
            par = 1'b0;
            for (int i = 0; i < FLEN; i++) begin
                if (i < P2S_SERIAL_LEN) data = data + (32'(q_bits[i]) << i);
                par = par ^ q_bits[i];
            end
            q_bits.delete();
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_word = data;
`ifdef S2P_PARITY_EN
                m_perr = par;
`else
                m_perr = 1'b0;
`endif
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("parallel_out", 32'(bus.parallel_out), m_word);
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input bit fs, input bit sin, input bit rdy);
        bus.frame_start = fs;
        bus.serial_in   = sin;
        bus.out_ready   = rdy;
        @(posedge clk);
        model_edge(fs, sin, rdy);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pout"}, 32'(bus.parallel_out), 32'h0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_ovr"}, 32'(bus.overrun), 32'h0);
        chk({tag, "_perr"}, 32'(bus.parity_err), 32'h0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [8:0] with_parity(input logic [7:0] w, input logic pbit);
        return {pbit, w};
    endfunction

    // Send n bits of a frame, frame_start on bit 0.
    task automatic send(input logic [8:0] frame, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(i == 0, frame[i], rdy);
    endtask

    initial begin
        logic [8:0] f;
        bus.frame_start = 1'b0;
        bus.serial_in   = 1'b0;
        bus.out_ready   = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);

        // 0xA5 with out_ready=1: valid on the final edge, cleared on the next.
        f = with_parity(8'hA5, ^8'hA5);
        send(f, FLEN, 1'b1);
        chk("a5_word", 32'(bus.parallel_out), 32'h0000_00A5);
        chk("a5_valid", 32'(bus.out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("a5_clear", 32'(bus.out_valid), 32'h0);

        // 0x3C then back-to-back 0xC3 with out_ready=0: second word dropped.
        f = with_parity(8'h3C, ^8'h3C);
        send(f, FLEN, 1'b0);
        f = with_parity(8'hC3, ^8'hC3);
        send(f, FLEN, 1'b0);
        chk("ovr_pulse", 32'(bus.overrun), 32'h1);
        chk("ovr_hold", 32'(bus.parallel_out), 32'h0000_003C);
        chk("ovr_valid", 32'(bus.out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr_one_cycle", 32'(bus.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // 0xFF aborted at bit 4 by a new 0x12 frame.
        f = with_parity(8'hFF, ^8'hFF);
        send(f, 4, 1'b1);
        f = with_parity(8'h12, ^8'h12);
        send(f, FLEN, 1'b1);
        chk("abort_word", 32'(bus.parallel_out), 32'h0000_0012);
        chk("abort_valid", 32'(bus.out_valid), 32'h1);
        chk("abort_ovr", 32'(bus.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Reset at bit 5, then serial activity without frame_start yields nothing.
        f = with_parity(8'h5A, ^8'h5A);
        send(f, 5, 1'b1);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i[0], 1'b1);
            chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        end

`ifdef S2P_PARITY_EN
        send(with_parity(8'h07, 1'b1), FLEN, 1'b1);
        chk("par_ok_valid", 32'(bus.out_valid), 32'h1);
        chk("par_ok_err", 32'(bus.parity_err), 32'h0);
        send(with_parity(8'h07, 1'b0), FLEN, 1'b1);
        chk("par_bad_valid", 32'(bus.out_valid), 32'h1);
        chk("par_bad_err", 32'(bus.parity_err), 32'h1);
        step(1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 997 == 996) do_reset();
            step($urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
